// File: rtl/instruction_prefetch_queue_if.sv
// Fetch-unit bus: instruction-memory read port, redirect request and the decode-facing queue head.
// Handshake: instr_valid/instr_ready. A transfer happens at the rising edge where both are high.
// While instr_valid is high, instruction and instr_pc stay stable until that transfer.
// instr_valid never depends on instr_ready.
interface instruction_prefetch_queue_if #(
  parameter int ADDRESS_WIDTH     = 9,
  parameter int INSTRUCTION_WIDTH = 32
);
  logic                         fetch_enable;
  logic                         mem_read_enable;
  logic [ADDRESS_WIDTH-3:0]     mem_read_address;
  logic [INSTRUCTION_WIDTH-1:0] mem_read_data;
  logic                         redirect;
  logic [ADDRESS_WIDTH-1:0]     redirect_pc;
  logic                         instr_valid;
  logic                         instr_ready;
  logic [INSTRUCTION_WIDTH-1:0] instruction;
  logic [ADDRESS_WIDTH-1:0]     instr_pc;

  modport master (
    input  fetch_enable, mem_read_data, redirect, redirect_pc, instr_ready,
    output mem_read_enable, mem_read_address, instr_valid, instruction, instr_pc
  );

  modport slave (
    output fetch_enable, mem_read_data, redirect, redirect_pc, instr_ready,
    input  mem_read_enable, mem_read_address, instr_valid, instruction, instr_pc
  );
endinterface

// File: rtl/instruction_prefetch_queue.sv
// Instruction fetch unit: owns the fetch PC, issues reads to a 1-cycle synchronous memory
// and buffers tagged words in a DEPTH-entry FIFO for decode; redirect flushes everything.
module instruction_prefetch_queue #(
  parameter int                       ADDRESS_WIDTH     = 9,
  parameter int                       INSTRUCTION_WIDTH = 32,
  parameter int                       DEPTH             = 4,
  parameter logic [ADDRESS_WIDTH-1:0] RESET_PC          = '0
) (
  input  logic                        clk,
  input  logic                        rst_n,
  instruction_prefetch_queue_if.master bus,
  output logic [1:0]                  dbg_state,
  output logic [$clog2(DEPTH):0]      dbg_count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {
    S_RUN       = 2'd0,
    S_FULL_HOLD = 2'd1,
    S_DISABLED  = 2'd2
  } state_t;

  state_t state, state_next;

  logic [ADDRESS_WIDTH-1:0]     fetch_pc;
  logic [ADDRESS_WIDTH-1:0]     pending_pc;
  logic                         pending;
  logic [INSTRUCTION_WIDTH-1:0] data_mem [DEPTH];
  logic [ADDRESS_WIDTH-1:0]     pc_mem   [DEPTH];
  logic [PW-1:0]                wr_ptr;
  logic [PW-1:0]                rd_ptr;
  logic [CW-1:0]                count;

  logic [CW:0]                  credit_used;
  logic                         credit_ok;
  logic                         issue;
  logic                         push;
  logic                         pop;
  logic                         head_valid;
  logic [CW-1:0]                count_next;
  logic                         pending_next;
  logic [CW:0]                  credit_next;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_RUN;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: classify the coming cycle from its credit and fetch_enable
  always_comb begin
    count_next   = count;
    pending_next = 1'b0;
    if (bus.redirect) begin
      count_next   = '0;
      pending_next = 1'b0;
    end else begin
      count_next   = count + CW'(push) - CW'(pop);
      pending_next = issue;
    end
    credit_next = {1'b0, count_next} + (CW+1)'(pending_next);

    state_next = state;
    if (bus.redirect) begin
      state_next = bus.fetch_enable ? S_RUN : S_DISABLED;
    end else if (!bus.fetch_enable) begin
      state_next = S_DISABLED;
    end else if (credit_next >= (CW+1)'(DEPTH)) begin
      state_next = S_FULL_HOLD;
    end else begin
      state_next = S_RUN;
    end
  end

  // Output logic: credit counts queued plus in-flight words; a pop frees credit only next cycle
  always_comb begin
    credit_used = {1'b0, count} + (CW+1)'(pending);
    credit_ok   = credit_used < (CW+1)'(DEPTH);
    issue       = rst_n && bus.fetch_enable && !bus.redirect && credit_ok;
    push        = rst_n && pending && !bus.redirect;
    head_valid  = rst_n && !bus.redirect && (count != '0);
    pop         = head_valid && bus.instr_ready;

    bus.mem_read_enable  = issue;
    bus.mem_read_address = rst_n ? fetch_pc[ADDRESS_WIDTH-1:2] : RESET_PC[ADDRESS_WIDTH-1:2];
    bus.instr_valid      = head_valid;
    bus.instruction      = head_valid ? data_mem[rd_ptr] : '0;
    bus.instr_pc         = head_valid ? pc_mem[rd_ptr] : '0;

    dbg_state = state;
    dbg_count = count;
  end

  // Control and pointers; redirect discards both queued and in-flight words
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fetch_pc   <= RESET_PC;
      pending_pc <= RESET_PC;
      pending    <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
    end else if (bus.redirect) begin
      fetch_pc   <= bus.redirect_pc & ~ADDRESS_WIDTH'(3);
      pending    <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
    end else begin
      if (issue) begin
        fetch_pc   <= fetch_pc + ADDRESS_WIDTH'(4);
        pending_pc <= fetch_pc;
      end
      pending <= issue;
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      count <= count_next;
    end
  end

  // Storage carries no reset; the pointers alone define what is valid
  always_ff @(posedge clk) begin
    if (push) begin
      data_mem[wr_ptr] <= bus.mem_read_data;
      pc_mem[wr_ptr]   <= pending_pc;
    end
  end
endmodule

// File: tb/tb_instruction_prefetch_queue.sv
// Bench for instruction_prefetch_queue: synchronous memory model, cycle-level reference queue
// compared every cycle, plus directed scenarios with hand-computed expectations.
module tb_instruction_prefetch_queue;
  localparam int AW    = 9;
  localparam int IW    = 32;
  localparam int DEPTH = 4;
  localparam logic [AW-1:0] RST_PC = 9'h000;

  // Clock and reset
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  instruction_prefetch_queue_if #(.ADDRESS_WIDTH(AW), .INSTRUCTION_WIDTH(IW)) bus();
  logic [1:0] dbg_state;
  logic [2:0] dbg_count;

  instruction_prefetch_queue #(
    .ADDRESS_WIDTH(AW), .INSTRUCTION_WIDTH(IW), .DEPTH(DEPTH), .RESET_PC(RST_PC)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .dbg_state(dbg_state), .dbg_count(dbg_count)
  );

  // Instruction memory: word n holds 0x1000_0000 + n, one cycle read latency
  always @(posedge clk) begin
    if (bus.mem_read_enable) bus.mem_read_data <= 32'h1000_0000 + 32'(bus.mem_read_address);
  end

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int n_issue = 0;
  logic [AW-1:0] deliv_q[$];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s (cycle %0d): got 0x%0h expected 0x%0h", name, cyc, got, exp);
    end
  endtask

  task automatic check_deliv(input string name, input int idx, input logic [AW-1:0] exp);
    if (idx < deliv_q.size()) begin
      check(name, 64'(deliv_q[idx]), 64'(exp));
    end else begin
      checks++;
      errors++;
      $display("FAIL %s: only %0d deliveries, wanted index %0d = 0x%0h", name, deliv_q.size(), idx, exp);
    end
  endtask

  // Scoreboard: words issued but not yet consumed, in order, with the cycle each becomes visible
  logic [AW+IW-1:0] exp_q[$];
  int               due_q[$];
  logic [AW-1:0]    model_pc = RST_PC;

  always @(negedge clk) begin
    logic            e_en, e_valid;
    logic [AW-3:0]   e_addr;
    logic [IW-1:0]   e_instr;
    logic [AW-1:0]   e_pc;
    cyc++;
    if (!rst_n) begin
      e_en = 1'b0; e_addr = RST_PC[AW-1:2]; e_valid = 1'b0; e_instr = '0; e_pc = '0;
    end else begin
      e_en    = bus.fetch_enable && !bus.redirect && (exp_q.size() < DEPTH);
      e_addr  = model_pc[AW-1:2];
      e_valid = !bus.redirect && (exp_q.size() > 0) && (cyc >= due_q[0]);
      e_pc    = e_valid ? exp_q[0][IW +: AW] : '0;
      e_instr = e_valid ? exp_q[0][IW-1:0] : '0;
    end
    check("cmp_mem_read_enable", 64'(bus.mem_read_enable), 64'(e_en));
    check("cmp_mem_read_address", 64'(bus.mem_read_address), 64'(e_addr));
    check("cmp_instr_valid", 64'(bus.instr_valid), 64'(e_valid));
    check("cmp_instruction", 64'(bus.instruction), 64'(e_instr));
    check("cmp_instr_pc", 64'(bus.instr_pc), 64'(e_pc));

    if (rst_n && bus.instr_valid && bus.instr_ready) deliv_q.push_back(bus.instr_pc);
    if (bus.mem_read_enable) n_issue++;

    if (!rst_n) begin
      exp_q.delete(); due_q.delete(); model_pc = RST_PC;
    end else if (bus.redirect) begin
      exp_q.delete(); due_q.delete(); model_pc = bus.redirect_pc & 9'h1FC;
    end else begin
      if (e_valid && bus.instr_ready) begin
        void'(exp_q.pop_front()); void'(due_q.pop_front());
      end
      if (e_en) begin
        exp_q.push_back({model_pc, 32'h1000_0000 + 32'(model_pc[AW-1:2])});
        due_q.push_back(cyc + 2);
        model_pc = model_pc + 9'd4;
      end
    end
  end

  // Driver helpers
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic sample();
    @(negedge clk); #1;
  endtask

  int base, issued0;

  initial begin
    rst_n = 1'b0;
    bus.fetch_enable = 1'b0;
    bus.instr_ready  = 1'b0;
    bus.redirect     = 1'b0;
    bus.redirect_pc  = '0;
    repeat (3) tick();

    // Reset release, streaming fetch
    rst_n = 1'b1; bus.fetch_enable = 1'b1; bus.instr_ready = 1'b1;
    sample();
    check("t1_en_c0", 64'(bus.mem_read_enable), 64'd1);
    check("t1_addr_c0", 64'(bus.mem_read_address), 64'h0);
    check("t1_valid_c0", 64'(bus.instr_valid), 64'd0);
    tick(); sample();
    check("t1_addr_c1", 64'(bus.mem_read_address), 64'h1);
    check("t1_valid_c1", 64'(bus.instr_valid), 64'd0);
    tick(); sample();
    check("t1_valid_c2", 64'(bus.instr_valid), 64'd1);
    check("t1_pc_c2", 64'(bus.instr_pc), 64'h000);
    check("t1_instr_c2", 64'(bus.instruction), 64'h1000_0000);
    tick(); sample();
    check("t1_pc_c3", 64'(bus.instr_pc), 64'h004);
    check("t1_addr_c3", 64'(bus.mem_read_address), 64'h3);
    check("t1_instr_c3", 64'(bus.instruction), 64'h1000_0001);
    repeat (5) tick();

    // Decode stalled: credit stops at DEPTH
    rst_n = 1'b0; tick();
    rst_n = 1'b1; bus.instr_ready = 1'b0;
    issued0 = n_issue; base = deliv_q.size();
    repeat (12) tick();
    sample();
    check("t2_issued", 64'(n_issue - issued0), 64'd4);
    check("t2_count", 64'(dbg_count), 64'd4);
    check("t2_en_held", 64'(bus.mem_read_enable), 64'd0);
    check("t2_valid", 64'(bus.instr_valid), 64'd1);
    tick(); bus.instr_ready = 1'b1;
    repeat (10) tick();
    check_deliv("t2_d0", base, 9'h000);
    check_deliv("t2_d1", base + 1, 9'h004);
    check_deliv("t2_d2", base + 2, 9'h008);
    check_deliv("t2_d3", base + 3, 9'h00C);
    check_deliv("t2_d4", base + 4, 9'h010);

    // Redirect with two queued words and one in flight
    rst_n = 1'b0; tick();
    rst_n = 1'b1; bus.instr_ready = 1'b0;
    repeat (3) tick();
    bus.redirect = 1'b1; bus.redirect_pc = 9'h046;
    base = deliv_q.size();
    sample();
    check("t3_count_before", 64'(dbg_count), 64'd2);
    check("t3_valid_redirect", 64'(bus.instr_valid), 64'd0);
    check("t3_en_redirect", 64'(bus.mem_read_enable), 64'd0);
    tick(); bus.redirect = 1'b0; bus.instr_ready = 1'b1;
    sample();
    check("t3_addr_after", 64'(bus.mem_read_address), 64'h11);
    check("t3_en_after", 64'(bus.mem_read_enable), 64'd1);
    repeat (6) tick();
    check_deliv("t3_first", base, 9'h044);
    check_deliv("t3_second", base + 1, 9'h048);

    // PC wrap at the top of the address space
    bus.redirect = 1'b1; bus.redirect_pc = 9'h1FC;
    base = deliv_q.size();
    tick(); bus.redirect = 1'b0;
    sample();
    check("t4_addr_top", 64'(bus.mem_read_address), 64'h7F);
    tick(); sample();
    check("t4_addr_wrap", 64'(bus.mem_read_address), 64'h00);
    repeat (4) tick();
    check_deliv("t4_d_top", base, 9'h1FC);
    check_deliv("t4_d_wrap", base + 1, 9'h000);

    // Reset while the queue is loaded and a read is pending
    bus.redirect = 1'b1; bus.redirect_pc = 9'h100; bus.instr_ready = 1'b0;
    tick(); bus.redirect = 1'b0;
    repeat (4) tick();
    rst_n = 1'b0;
    sample();
    check("t5_count_loaded", 64'(dbg_count), 64'd3);
    check("t5_en_rst", 64'(bus.mem_read_enable), 64'd0);
    check("t5_valid_rst", 64'(bus.instr_valid), 64'd0);
    check("t5_pc_rst", 64'(bus.instr_pc), 64'h0);
    check("t5_instr_rst", 64'(bus.instruction), 64'h0);
    tick(); rst_n = 1'b1; bus.instr_ready = 1'b1;
    base = deliv_q.size();
    sample();
    check("t5_count_after", 64'(dbg_count), 64'd0);
    check("t5_addr_after", 64'(bus.mem_read_address), 64'h0);
    repeat (5) tick();
    check_deliv("t5_first", base, RST_PC);

    // fetch_enable toggling with random decode back-pressure
    bus.redirect = 1'b1; bus.redirect_pc = 9'h080;
    tick(); bus.redirect = 1'b0;
    base = deliv_q.size();
    for (int i = 0; i < 60; i++) begin
      bus.fetch_enable = (i % 2 == 0);
      bus.instr_ready  = 1'($urandom_range(0, 1));
      tick();
    end
    bus.fetch_enable = 1'b0; bus.instr_ready = 1'b1;
    repeat (8) tick();
    sample();
    check("t6_drained", 64'(dbg_count), 64'd0);
    check("t6_enough", 64'(deliv_q.size() - base >= 10), 64'd1);
    check_deliv("t6_first", base, 9'h080);
    for (int i = base; i + 1 < deliv_q.size(); i++) begin
      check("t6_consecutive", 64'(deliv_q[i+1]), 64'(deliv_q[i] + 9'd4));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
